// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants, FSM state encoding and opcode legality helper
package alu_pkg;

  localparam logic [3:0] OP_ROL  = 4'd0;
  localparam logic [3:0] OP_ROR  = 4'd1;
  localparam logic [3:0] OP_MAX  = 4'd2;
  localparam logic [3:0] OP_MIN  = 4'd3;
  localparam logic [3:0] OP_SGT  = 4'd4;
  localparam logic [3:0] OP_LAST = OP_SGT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic op_illegal(input logic [3:0] op);
    return op > OP_LAST;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant: first active requester at or after the pointer
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  int best_rank;
  int rank;

  // Rank is the wrapped distance from the pointer; the smallest active rank wins.
  always_comb begin
    gnt_o     = '0;
    idx_o     = '0;
    best_rank = NREQ;
    rank      = 0;
    for (int j = 0; j < NREQ; j++) begin
      rank = (j + NREQ - int'(ptr_i)) % NREQ;
      if (req_i[j] && (rank < best_rank)) begin
        best_rank = rank;
        idx_o     = IDW'(j);
        gnt_o     = '0;
        gnt_o[j]  = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/alu_req_scheduler.sv
// rtl/alu_req_scheduler.sv - shares one external combinational ALU among NREQ requesters
module alu_req_scheduler
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = 8,
  parameter int IDW  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*4-1:0] req_opcode,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*5-1:0] req_shift,
  output logic [3:0]        alu_opcode,
  output logic [W-1:0]      alu_in1,
  output logic [W-1:0]      alu_in2,
  output logic [4:0]        alu_shift,
  input  logic [W-1:0]      alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [W-1:0]      rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              busy
);

  state_e         state_q;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gid_q;
  logic [3:0]     op_q;
  logic [W-1:0]   a_q, b_q;
  logic [4:0]     sh_q;
  logic           err_q;
  logic           rsp_valid_q, rsp_zero_q, rsp_err_q;
  logic [IDW-1:0] rsp_id_q;
  logic [W-1:0]   rsp_result_q;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;

  rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .req_i(req_valid),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(gnt_idx),
    .any_o(gnt_any)
  );

  logic [3:0]   sel_op;
  logic [W-1:0] sel_a, sel_b;
  logic [4:0]   sel_sh;
  logic         unused_sh_hi;

  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    sel_sh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_op = req_opcode[4*i +: 4];
        sel_a  = req_a[W*i +: W];
        sel_b  = req_b[W*i +: W];
        sel_sh = req_shift[5*i +: 5];
      end
    end
  end

  // Shift amounts are reduced mod 8 before reaching the ALU.
  assign unused_sh_hi = ^sel_sh[4:3];

  assign req_ready = (state_q == ST_IDLE) ? gnt : '0;
  assign ptr_d     = (rsp_id_q == IDW'(NREQ - 1)) ? '0 : rsp_id_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      gid_q        <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      sh_q         <= '0;
      err_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_any) begin
            gid_q   <= gnt_idx;
            err_q   <= op_illegal(sel_op);
            op_q    <= op_illegal(sel_op) ? 4'd0 : sel_op;
            a_q     <= sel_a;
            b_q     <= sel_b;
            sh_q    <= {2'b00, sel_sh[2:0]};
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_result_q <= err_q ? '0 : alu_result;
          rsp_zero_q   <= err_q ? 1'b1 : (alu_result == '0);
          rsp_err_q    <= err_q;
          rsp_id_q     <= gid_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ptr_q       <= ptr_d;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alu_opcode = op_q;
  assign alu_in1    = a_q;
  assign alu_in2    = b_q;
  assign alu_shift  = sh_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_req_scheduler.sv
// tb/tb_alu_req_scheduler.sv - scenario tasks plus randomized traffic against a behavioural model
module tb_alu_req_scheduler;

  localparam int NREQ = 2;
  localparam int W    = 8;
  localparam int IDW  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*4-1:0] req_opcode;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ*5-1:0] req_shift;
  logic [3:0]        alu_opcode;
  logic [W-1:0]      alu_in1, alu_in2, alu_result;
  logic [4:0]        alu_shift;
  logic              rsp_valid, rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_result;
  logic              rsp_zero, rsp_err, busy;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;
  int cmd_op[NREQ], cmd_a[NREQ], cmd_b[NREQ], cmd_sh[NREQ];

  always #5 clk = ~clk;

  alu_req_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b), .req_shift(req_shift),
    .alu_opcode(alu_opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_shift(alu_shift), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );

  // Stand-in ALU: rotates step by step using the full shift value it is given.
  function automatic logic [7:0] rot(input logic [7:0] v, input logic [4:0] n, input logic left);
    logic [7:0] r;
    r = v;
    for (int k = 0; k < int'(n); k++) r = left ? {r[6:0], r[7]} : {r[0], r[7:1]};
    return r;
  endfunction

  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      4'd0: alu_result = rot(alu_in1, alu_shift, 1'b1);
      4'd1: alu_result = rot(alu_in1, alu_shift, 1'b0);
      4'd2: alu_result = (alu_in1 > alu_in2) ? alu_in1 : alu_in2;
      4'd3: alu_result = (alu_in1 < alu_in2) ? alu_in1 : alu_in2;
      4'd4: alu_result = {7'd0, $signed(alu_in1) > $signed(alu_in2)};
      default: alu_result = 8'hee;
    endcase
  end

  function automatic int model_result(input int op, input int a, input int b, input int sh);
    int n, sa, sb;
    n  = sh % 8;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    case (op)
      0: return ((a << n) | (a >> (8 - n))) & 255;
      1: return ((a >> n) | (a << (8 - n))) & 255;
      2: return (a > b) ? a : b;
      3: return (a < b) ? a : b;
      4: return (sa > sb) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  function automatic int model_grant(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int op, input int a, input int b, input int sh);
    req_opcode[4*i +: 4] = 4'(op);
    req_a[W*i +: W]      = W'(a);
    req_b[W*i +: W]      = W'(b);
    req_shift[5*i +: 5]  = 5'(sh);
    req_valid[i]         = 1'b1;
    cmd_op[i] = op; cmd_a[i] = a; cmd_b[i] = b; cmd_sh[i] = sh;
  endtask

  task automatic wait_grant(output int gid, output int cyc);
    gid = -1;
    cyc = 0;
    while (cyc < 40) begin
      if (req_ready != '0) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
        return;
      end
      step();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_opcode = '0; req_a = '0; req_b = '0;
    req_shift = '0; rsp_ready = 1'b0;
    repeat (3) step();
    checks++;
    if ({rsp_valid, busy, rsp_zero, rsp_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {rsp_valid, busy, rsp_zero, rsp_err});
    end
    checks++;
    if (rsp_result !== 8'h00 || rsp_id !== 3'd0) begin
      errors++; $display("FAIL reset_rsp got result=%h id=%0d want 0/0", rsp_result, rsp_id);
    end
    checks++;
    if (alu_opcode !== 4'd0 || alu_in1 !== 8'h00 || alu_in2 !== 8'h00 || alu_shift !== 5'd0) begin
      errors++; $display("FAIL reset_alu got op=%h a=%h b=%h sh=%h want zeros", alu_opcode, alu_in1, alu_in2, alu_shift);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (req_ready !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_no_req got ready=%b busy=%b want 00/0", req_ready, busy);
    end
    ptr_m = 0;
  endtask

  task automatic test_rol_latency();
    int gid, cyc;
    set_req(0, 0, 8'h81, 8'h00, 1);
    rsp_ready = 1'b1;
    #1;
    wait_grant(gid, cyc);
    checks++;
    if (gid !== 0 || cyc !== 0) begin
      errors++; $display("FAIL rol_grant got id=%0d wait=%0d want 0/0", gid, cyc);
    end
    step();
    req_valid[0] = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1 || alu_in1 !== 8'h81 || alu_shift !== 5'd1 || req_ready !== 2'b00) begin
      errors++; $display("FAIL rol_exec got v=%b busy=%b a=%h sh=%0d rdy=%b want 0/1/81/1/00", rsp_valid, busy, alu_in1, alu_shift, req_ready);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 8'h03 || rsp_id !== 3'd0 || rsp_err !== 1'b0 || rsp_zero !== 1'b0) begin
      errors++; $display("FAIL rol_rsp got v=%b r=%h id=%0d e=%b z=%b want 1/03/0/0/0", rsp_valid, rsp_result, rsp_id, rsp_err, rsp_zero);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rol_done got v=%b busy=%b want 0/0", rsp_valid, busy);
    end
    ptr_m = 1;
  endtask

  task automatic test_alternate();
    int gid, cyc, exp;
    set_req(0, 2, 8'h37, 8'h9a, 0);
    set_req(1, 0, 8'hc3, 8'h00, 2);
    rsp_ready = 1'b1;
    #1;
    for (int n = 0; n < 4; n++) begin
      wait_grant(gid, cyc);
      exp = ptr_m;
      checks++;
      if (gid !== exp || cyc !== 0) begin
        errors++; $display("FAIL alt_grant[%0d] got id=%0d wait=%0d want %0d/0", n, gid, cyc, exp);
      end
      step();
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== IDW'(exp) ||
          rsp_result !== 8'(model_result(cmd_op[exp], cmd_a[exp], cmd_b[exp], cmd_sh[exp]))) begin
        errors++; $display("FAIL alt_rsp[%0d] got v=%b id=%0d r=%h want 1/%0d/%h", n, rsp_valid, rsp_id, rsp_result,
                           exp, 8'(model_result(cmd_op[exp], cmd_a[exp], cmd_b[exp], cmd_sh[exp])));
      end
      ptr_m = (exp + 1) % NREQ;
      step();
    end
    req_valid = '0;
    #1;
  endtask

  task automatic test_backpressure();
    int gid, cyc, bad;
    set_req(1, 3, 5, 5, 0);
    rsp_ready = 1'b0;
    #1;
    wait_grant(gid, cyc);
    checks++;
    if (gid !== 1) begin
      errors++; $display("FAIL bp_grant got %0d want 1", gid);
    end
    step();
    req_valid[1] = 1'b0;
    set_req(0, 2, 8'h10, 8'h20, 0);
    step();
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      if (rsp_valid !== 1'b1 || rsp_result !== 8'd5 || rsp_id !== 3'd1 || rsp_zero !== 1'b0 ||
          rsp_err !== 1'b0 || req_ready !== 2'b00) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL bp_stable got %0d unstable cycles want 0", bad);
    end
    rsp_ready = 1'b1;
    step();
    ptr_m = 0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 2'b01) begin
      errors++; $display("FAIL bp_release got v=%b rdy=%b want 0/01", rsp_valid, req_ready);
    end
    step();
    req_valid[0] = 1'b0;
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_result !== 8'h20 || rsp_id !== 3'd0) begin
      errors++; $display("FAIL bp_next got v=%b r=%h id=%0d want 1/20/0", rsp_valid, rsp_result, rsp_id);
    end
    step();
    ptr_m = 1;
  endtask

  task automatic test_illegal();
    int gid, cyc;
    set_req(1, 9, 8'h3c, 8'h11, 2);
    rsp_ready = 1'b1;
    #1;
    wait_grant(gid, cyc);
    step();
    req_valid[1] = 1'b0;
    checks++;
    if (alu_opcode !== 4'd0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL illegal_exec got op=%0d v=%b want 0/0", alu_opcode, rsp_valid);
    end
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_result !== 8'h00 || rsp_zero !== 1'b1 || rsp_id !== 3'd1) begin
      errors++; $display("FAIL illegal_rsp got v=%b e=%b r=%h z=%b id=%0d want 1/1/00/1/1", rsp_valid, rsp_err, rsp_result, rsp_zero, rsp_id);
    end
    step();
    ptr_m = 0;
  endtask

  task automatic test_shift_and_zero();
    int gid, cyc, id, op, a, b, sh, e_sh, e_res, e_z;
    rsp_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      case (n)
        0:       begin id = 1; op = 1; a = 8'h01; b = 0; sh = 9; e_sh = 1; e_res = 8'h80; e_z = 0; end
        1:       begin id = 0; op = 2; a = 0;     b = 0; sh = 0; e_sh = 0; e_res = 0;     e_z = 1; end
        default: begin id = 1; op = 0; a = 8'ha5; b = 0; sh = 8; e_sh = 0; e_res = 8'ha5; e_z = 0; end
      endcase
      set_req(id, op, a, b, sh);
      #1;
      wait_grant(gid, cyc);
      checks++;
      if (gid !== id) begin
        errors++; $display("FAIL sz_grant[%0d] got %0d want %0d", n, gid, id);
      end
      step();
      req_valid[id] = 1'b0;
      checks++;
      if (alu_shift !== 5'(e_sh) || alu_opcode !== 4'(op)) begin
        errors++; $display("FAIL sz_alu[%0d] got sh=%0d op=%0d want %0d/%0d", n, alu_shift, alu_opcode, e_sh, op);
      end
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 8'(e_res) || rsp_zero !== 1'(e_z) || rsp_err !== 1'b0) begin
        errors++; $display("FAIL sz_rsp[%0d] got v=%b r=%h z=%b e=%b want 1/%h/%0d/0", n, rsp_valid, rsp_result, rsp_zero, rsp_err, e_res, e_z);
      end
      step();
      ptr_m = (id + 1) % NREQ;
    end
  endtask

  task automatic test_reset_in_exec();
    int gid, cyc, seen;
    rsp_ready = 1'b1;
    set_req(0, 0, 8'h12, 0, 3);
    #1;
    wait_grant(gid, cyc);
    step();
    req_valid[0] = 1'b0;
    step();
    step();
    set_req(0, 2, 8'h44, 8'h55, 0);
    #1;
    wait_grant(gid, cyc);
    checks++;
    if (gid !== 0) begin
      errors++; $display("FAIL rx_grant got %0d want 0", gid);
    end
    step();
    rst_n = 1'b0;
    req_valid = '0;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL rx_async got busy=%b v=%b want 0/0", busy, rsp_valid);
    end
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 6; n++) begin
      step();
      if (rsp_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL rx_no_rsp got %0d valid cycles want 0", seen);
    end
    ptr_m = 0;
    set_req(0, 3, 8'h09, 8'h07, 0);
    set_req(1, 3, 8'h01, 8'h02, 0);
    #1;
    checks++;
    if (req_ready !== 2'b01) begin
      errors++; $display("FAIL rx_ptr got rdy=%b want 01", req_ready);
    end
    step();
    req_valid[0] = 1'b0;
    step();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 3'd0 || rsp_result !== 8'h07) begin
      errors++; $display("FAIL rx_after got v=%b id=%0d r=%h want 1/0/07", rsp_valid, rsp_id, rsp_result);
    end
    step();
    ptr_m = 1;
  endtask

  task automatic test_random();
    int exp, stall, bad, e_res, op;
    logic [NREQ-1:0] ev;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) != 0) begin
          op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 15)) : int'($urandom_range(0, 4));
          set_req(i, op, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 31)));
        end
      end
      if (req_valid == '0) set_req(int'($urandom_range(0, NREQ - 1)), int'($urandom_range(0, 4)),
                                   int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 31)));
      #1;
      exp = model_grant(req_valid, ptr_m);
      ev = '0;
      ev[exp] = 1'b1;
      checks++;
      if (req_ready !== ev) begin
        errors++; $display("FAIL rnd_grant[%0d] got %b want %b", it, req_ready, ev);
      end
      rsp_ready = 1'b0;
      step();
      req_valid[exp] = 1'b0;
      for (int i = 0; i < NREQ; i++) if ($urandom_range(0, 5) == 0) req_valid[i] = 1'b0;
      step();
      e_res = model_result(cmd_op[exp], cmd_a[exp], cmd_b[exp], cmd_sh[exp]);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== IDW'(exp) || rsp_result !== 8'(e_res) ||
          rsp_zero !== (e_res == 0) || rsp_err !== (cmd_op[exp] > 4)) begin
        errors++; $display("FAIL rnd_rsp[%0d] got v=%b id=%0d r=%h z=%b e=%b want 1/%0d/%h/%0d/%0d", it, rsp_valid, rsp_id,
                           rsp_result, rsp_zero, rsp_err, exp, e_res, e_res == 0, cmd_op[exp] > 4);
      end
      stall = int'($urandom_range(0, 3));
      bad = 0;
      for (int s = 0; s < stall; s++) begin
        step();
        if (rsp_valid !== 1'b1 || rsp_result !== 8'(e_res) || rsp_id !== IDW'(exp) || req_ready !== '0) bad++;
      end
      rsp_ready = 1'b1;
      step();
      rsp_ready = 1'b0;
      ptr_m = (exp + 1) % NREQ;
      checks++;
      if (bad != 0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rnd_hold[%0d] got bad=%0d v=%b busy=%b want 0/0/0", it, bad, rsp_valid, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rol_latency();
    test_alternate();
    test_backpressure();
    test_illegal();
    test_shift_and_zero();
    test_reset_in_exec();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after 500000 time units");
    $fatal(1, "watchdog");
  end

endmodule
